// File: rtl/ldm_stm_sequencer_pkg.sv
// Shared types and helpers for the LDM/STM block-transfer sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ldm_stm_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        WB   = 2'd2,
        DONE = 2'd3
    } seqState_t;

    localparam int         WORD_BYTES = 4;
    localparam logic [3:0] PC_IDX     = 4'd15;

    // Number of registers named in a 16-entry register list.
    function automatic logic [4:0] popCount16(input logic [15:0] list);
        logic [4:0] cnt;
        cnt = '0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + {4'd0, list[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/ldm_stm_sequencer_reg_list_scan.sv
// Lowest-set-bit priority encoder over the remaining register list.
// Latency: combinational.
// Backpressure: none; pure function of the list.
module ldm_stm_sequencer_reg_list_scan #(
    parameter int NREG = 16
) (
    input  logic [NREG-1:0] list,
    output logic [3:0]      index,
    output logic            valid,
    output logic            last
);

    localparam logic [NREG-1:0] ONE = NREG'(1);

    // Scan from the top so the lowest set bit is the one that sticks.
    always_comb begin
        index = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (list[i]) begin
                index = i[3:0];
            end
        end
    end

    assign valid = |list;
    // Removing the lowest set bit leaves nothing -> exactly one bit set.
    assign last  = valid && ((list & (list - ONE)) == '0);

endmodule

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM sequencer: walks a register list, one memory access per register, optional base writeback.
// Latency: n accesses + optional writeback cycle + one done cycle after start.
// Backpressure: each access holds mem_req/mem_addr until mem_ack; no timeout; start ignored while busy.
module ldm_stm_sequencer
    import ldm_stm_sequencer_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREG   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              is_load,
    input  logic              pre_index,
    input  logic              up,
    input  logic              wback,
    input  logic [3:0]        base_reg,
    input  logic [DATA_W-1:0] base_val,
    input  logic [NREG-1:0]   reg_list,
    output logic [3:0]        rf_read_reg,
    input  logic [DATA_W-1:0] rf_read_data,
    output logic [3:0]        rf_write_dest,
    output logic              rf_write_en,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              pc_loaded
);

    localparam logic [DATA_W-1:0] WORD_STEP = DATA_W'(WORD_BYTES);
    localparam logic [NREG-1:0]   LIST_ONE  = NREG'(1);

    seqState_t         state, nextState;
    logic [NREG-1:0]   listRem;
    logic [DATA_W-1:0] curAddr;
    logic [DATA_W-1:0] finalAddr;
    logic              isLoadQ;
    logic              wbackQ;
    logic              skipWb;
    logic [3:0]        baseRegQ;

    logic [3:0]        curIdx;
    logic              curValid;
    logic              curLast;

    logic [4:0]        nRegs;
    logic [DATA_W-1:0] span;
    logic [DATA_W-1:0] startAddr;
    logic [DATA_W-1:0] finalAddrD;

    ldm_stm_sequencer_reg_list_scan #(.NREG(NREG)) u_scan (
        .list  (listRem),
        .index (curIdx),
        .valid (curValid),
        .last  (curLast)
    );

    // Block address range: transfers always go lowest register to lowest address.
    always_comb begin
        nRegs      = popCount16(reg_list);
        span       = DATA_W'(nRegs) * WORD_STEP;
        if (up) begin
            startAddr  = base_val + (pre_index ? WORD_STEP : '0);
            finalAddrD = base_val + span;
        end else begin
            startAddr  = base_val - span + (pre_index ? '0 : WORD_STEP);
            finalAddrD = base_val - span;
        end
    end

    // State register plus request capture and per-access list/address advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            listRem   <= '0;
            curAddr   <= '0;
            finalAddr <= '0;
            isLoadQ   <= 1'b0;
            wbackQ    <= 1'b0;
            skipWb    <= 1'b0;
            baseRegQ  <= '0;
        end else begin
            state <= nextState;
            case (state)
                IDLE: begin
                    if (start) begin
                        listRem   <= reg_list;
                        curAddr   <= startAddr;
                        finalAddr <= finalAddrD;
                        isLoadQ   <= is_load;
                        wbackQ    <= wback;
                        baseRegQ  <= base_reg;
                        // A loaded base register beats the writeback value.
                        skipWb    <= is_load && reg_list[base_reg];
                    end
                end
                XFER: begin
                    if (mem_ack) begin
                        listRem <= listRem & (listRem - LIST_ONE);
                        curAddr <= curAddr + WORD_STEP;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next state and all outputs; register/memory writes are squashed while reset is high.
    always_comb begin
        nextState     = state;
        rf_read_reg   = '0;
        rf_write_dest = '0;
        rf_write_en   = 1'b0;
        rf_write_data = '0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        busy          = 1'b1;
        done          = 1'b0;
        pc_loaded     = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    nextState = (reg_list != '0) ? XFER : DONE;
                end
            end
            XFER: begin
                mem_req  = curValid;
                mem_addr = curAddr;
                mem_we   = !isLoadQ;
                if (!isLoadQ) begin
                    rf_read_reg = curIdx;
                    mem_wdata   = rf_read_data;
                end
                if (mem_ack) begin
                    if (isLoadQ) begin
                        rf_write_en   = 1'b1;
                        rf_write_dest = curIdx;
                        rf_write_data = mem_rdata;
                        pc_loaded     = (curIdx == PC_IDX);
                    end
                    if (curLast) begin
                        nextState = wbackQ ? WB : DONE;
                    end
                end
            end
            WB: begin
                if (!skipWb) begin
                    rf_write_en   = 1'b1;
                    rf_write_dest = baseRegQ;
                    rf_write_data = finalAddr;
                end
                nextState = DONE;
            end
            DONE: begin
                done      = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
        if (reset) begin
            rf_write_en = 1'b0;
            mem_req     = 1'b0;
            mem_we      = 1'b0;
            pc_loaded   = 1'b0;
        end
    end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Scoreboard bench for ldm_stm_sequencer: directed block transfers plus randomized requests.
// Latency: n/a.
// Backpressure: memory responder inserts per-access wait states chosen by the stimulus.
module tb_ldm_stm_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        is_load;
    logic        pre_index;
    logic        up;
    logic        wback;
    logic [3:0]  base_reg;
    logic [31:0] base_val;
    logic [15:0] reg_list;
    logic [3:0]  rf_read_reg;
    logic [31:0] rf_read_data;
    logic [3:0]  rf_write_dest;
    logic        rf_write_en;
    logic [31:0] rf_write_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        done;
    logic        pc_loaded;

    ldm_stm_sequencer #(.DATA_W(32), .NREG(16)) dut (
        .clk(clk), .reset(reset), .start(start), .is_load(is_load),
        .pre_index(pre_index), .up(up), .wback(wback), .base_reg(base_reg),
        .base_val(base_val), .reg_list(reg_list), .rf_read_reg(rf_read_reg),
        .rf_read_data(rf_read_data), .rf_write_dest(rf_write_dest),
        .rf_write_en(rf_write_en), .rf_write_data(rf_write_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .pc_loaded(pc_loaded)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; } acc_t;
    typedef struct { logic [3:0] dest; logic [31:0] data; logic pc; } wr_t;

    acc_t        memQ[$];
    wr_t         wrQ[$];
    int          doneQ[$];
    int          waitQ[$];
    logic [31:0] rfInit[16];
    logic [31:0] salt;
    bit          plainData;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          respArmed;
    int          respCnt;

    always @(posedge clk) cyc <= cyc + 1;

    assign rf_read_data = rfInit[rf_read_reg];

    // Memory contents seen by loads: a fixed ramp for the directed case, a salted hash otherwise.
    function automatic logic [31:0] memData(input logic [31:0] addr);
        if (plainData) return 32'hA1 + ((addr - 32'h100) >> 2);
        return (addr * 32'h9E3779B1) ^ salt;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flushAll();
        memQ.delete();
        wrQ.delete();
        doneQ.delete();
        waitQ.delete();
    endtask

    // Memory responder: each access waits the number of cycles queued by the stimulus, then acks.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        respArmed = 1'b0;
        respCnt   = 0;
        forever begin
            @(posedge clk);
            #2;
            if (reset) begin
                respArmed = 1'b0;
                mem_ack   = 1'b0;
                mem_rdata = '0;
            end else begin
                if (mem_ack) respArmed = 1'b0;
                if (mem_req && !respArmed) begin
                    respArmed = 1'b1;
                    respCnt   = (waitQ.size() > 0) ? waitQ.pop_front() : 0;
                end
                if (respArmed && respCnt == 0) begin
                    mem_ack   = 1'b1;
                    mem_rdata = memData(mem_addr);
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = $urandom;
                    if (respArmed) respCnt--;
                end
            end
        end
    end

    // Monitor: compares every DUT memory access, register write and done pulse against the queues.
    always @(negedge clk) begin : monitor
        wr_t  w;
        acc_t a;
        int   d;
        if (!reset) begin
            if (rf_write_en) begin
                if (wrQ.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_rf_write: dest %0d data %h, none expected (cycle %0d)",
                             rf_write_dest, rf_write_data, cyc);
                end else begin
                    w = wrQ.pop_front();
                    check("rf_write_dest", 32'(rf_write_dest), 32'(w.dest));
                    check("rf_write_data", rf_write_data, w.data);
                    check("pc_loaded", 32'(pc_loaded), 32'(w.pc));
                end
            end else if (pc_loaded) begin
                checks++; errors++;
                $display("FAIL pc_loaded_without_write: got 1 expected 0 (cycle %0d)", cyc);
            end
            if (mem_req) begin
                if (memQ.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_mem_req: addr %h we %0d, none expected (cycle %0d)",
                             mem_addr, mem_we, cyc);
                end else begin
                    a = memQ[0];
                    check("mem_addr", mem_addr, a.addr);
                    check("mem_we", 32'(mem_we), 32'(a.we));
                    if (a.we) check("mem_wdata", mem_wdata, a.wdata);
                    if (mem_ack) void'(memQ.pop_front());
                end
            end
            if (done) begin
                if (doneQ.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got pulse expected none (cycle %0d)", cyc);
                end else begin
                    d = doneQ.pop_front();
                    check("done_cycle", 32'(cyc), 32'(d));
                    check("busy_in_done", 32'(busy), 32'd1);
                end
            end
        end
    end

    // Reference model: derive accesses, register writes and done time from the request, then start it.
    task automatic issueOp(input bit ld, input bit pre, input bit upd, input bit wb,
                           input logic [3:0] br, input logic [31:0] bv, input logic [15:0] lst,
                           input int minWait, input int maxWait);
        int          n;
        int          total;
        int          w;
        logic [31:0] lo;
        logic [31:0] fin;
        logic [31:0] addr;
        @(posedge clk);
        #1;
        n   = $countones(lst);
        lo  = upd ? (pre ? bv + 32'd4 : bv) : (pre ? bv - 32'(4 * n) : bv - 32'(4 * n) + 32'd4);
        fin = upd ? bv + 32'(4 * n) : bv - 32'(4 * n);
        salt  = $urandom;
        total = 0;
        addr  = lo;
        for (int r = 0; r < 16; r++) begin
            if (lst[r]) begin
                w = $urandom_range(maxWait, minWait);
                waitQ.push_back(w);
                total += w + 1;
                memQ.push_back('{addr, !ld, ld ? 32'h0 : rfInit[r]});
                if (ld) wrQ.push_back('{4'(r), memData(addr), r == 15});
                addr += 32'd4;
            end
        end
        if (wb && n > 0) begin
            total += 1;
            if (!(ld && lst[br])) wrQ.push_back('{br, fin, 1'b0});
        end
        doneQ.push_back(cyc + total + 1);
        is_load = ld; pre_index = pre; up = upd; wback = wb;
        base_reg = br; base_val = bv; reg_list = lst;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        is_load = 1'($urandom); pre_index = 1'($urandom); up = 1'($urandom);
        wback = 1'($urandom); base_reg = 4'($urandom); base_val = $urandom;
        reg_list = 16'($urandom);
    endtask

    task automatic waitOp(input string name);
        int guard;
        guard = 0;
        while (doneQ.size() > 0 && guard < 400) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (doneQ.size() > 0) begin
            checks++; errors++;
            $display("FAIL %s_timeout: done not seen within %0d cycles", name, guard);
            flushAll();
        end
        check({name, "_mem_left"}, 32'(memQ.size()), 32'd0);
        check({name, "_wr_left"}, 32'(wrQ.size()), 32'd0);
        check({name, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int guard;
        int mode;
        logic [15:0] lst;
        reset = 1'b1; start = 1'b0; is_load = 1'b0; pre_index = 1'b0; up = 1'b0;
        wback = 1'b0; base_reg = '0; base_val = '0; reg_list = '0; plainData = 1'b0;
        salt = '0;
        for (int i = 0; i < 16; i++) rfInit[i] = $urandom;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rf_write_en", 32'(rf_write_en), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_pc_loaded", 32'(pc_loaded), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_rf_write_dest", 32'(rf_write_dest), 32'd0);
        check("rst_rf_write_data", rf_write_data, 32'd0);
        reset = 1'b0;

        // LDM IA with writeback: R1..R3 from 0x100, base gets 0x10C, done 5 cycles after start.
        plainData = 1'b1;
        issueOp(1'b1, 1'b0, 1'b1, 1'b1, 4'd5, 32'h100, 16'h000E, 0, 0);
        waitOp("ldm_ia_wb");
        plainData = 1'b0;

        // STM DB: R4 @0x1F8, R14 @0x1FC, no register writes.
        issueOp(1'b0, 1'b1, 1'b0, 1'b0, 4'd9, 32'h200, 16'h4010, 0, 0);
        waitOp("stm_db");

        // Wait states of three cycles on every access.
        issueOp(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 32'h4000, 16'h0131, 3, 3);
        waitOp("wait_states");

        // Loaded base register wins over writeback.
        issueOp(1'b1, 1'b1, 1'b1, 1'b1, 4'd2, 32'h800, 16'h0006, 0, 2);
        waitOp("base_in_list");

        // PC load, then an empty list with writeback requested.
        issueOp(1'b1, 1'b0, 1'b0, 1'b0, 4'd13, 32'h3000, 16'h8000, 0, 1);
        waitOp("pc_load");
        issueOp(1'b1, 1'b0, 1'b1, 1'b1, 4'd3, 32'h500, 16'h0000, 0, 0);
        waitOp("empty_list");

        // Start pulse while busy must not queue a second operation.
        issueOp(1'b0, 1'b0, 1'b1, 1'b1, 4'd7, 32'h6000, 16'h00F0, 2, 3);
        @(posedge clk);
        #1;
        is_load = 1'b1; reg_list = 16'hFFFF; wback = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitOp("start_busy");

        // Reset during the second of three load transfers.
        issueOp(1'b1, 1'b0, 1'b1, 1'b1, 4'd8, 32'h7000, 16'h0007, 2, 2);
        guard = 0;
        while (memQ.size() > 2 && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("reset_reach_second", 32'(memQ.size()), 32'd2);
        reset = 1'b1;
        flushAll();
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_mid_busy", 32'(busy), 32'd0);
        check("reset_mid_mem_req", 32'(mem_req), 32'd0);
        check("reset_mid_rf_we", 32'(rf_write_en), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check("reset_mid_still_idle", 32'(busy), 32'd0);

        // Randomized requests.
        for (int t = 0; t < 60; t++) begin
            mode = $urandom_range(5, 0);
            if (mode == 0)      lst = 16'h0000;
            else if (mode == 1) lst = 16'(1 << $urandom_range(15, 0));
            else if (mode == 2) lst = 16'($urandom) | 16'h8000;
            else                lst = 16'($urandom);
            issueOp(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                    4'($urandom), $urandom & 32'hFFFF_FFFC, lst, 0, 3);
            waitOp("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
